delay_pulse_burst: RTL and testbench
====================================

Name: delay_pulse_burst

Overview:
Multi-channel, parameterised delay/pulse generator with per-channel burst capability.
- A rising edge on the shared t0 arms every enabled channel.
- Each armed channel waits its programmed delay, then emits a programmed number of pulses of programmed width at a programmed period.
- Used for the timing/trigger fabric (injection, gate, ADC-start strobes) where several phase-locked outputs are needed from one trigger.

Parameters:
NCH, 4, number of independent output channels (1..16)
WIDTH, 32, width of delay, width and period counters per channel
CNT_W, 8, width of per-channel burst pulse count

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
t0  in  1  trigger; level input, rising edge detected internally (no single-cycle requirement)
abort  in  1  synchronous abort: all channels to IDLE
enable  in  NCH  per-channel enable, sampled at t0 edge
pol  in  NCH  per-channel output polarity (1 = active-low output)
delay  in  NCH*WIDTH  per-channel delay in clocks, channel i at [i*WIDTH +: WIDTH]
width  in  NCH*WIDTH  per-channel pulse width in clocks
period  in  NCH*WIDTH  per-channel rising-edge-to-rising-edge spacing within a burst
count  in  NCH*CNT_W  per-channel number of pulses in the burst
clr_overrun  in  1  one-cycle pulse, clears all overrun flags
pinout  out  NCH  pulse outputs (registered)
busy  out  NCH  channel is not IDLE (registered)
overrun  out  NCH  sticky: t0 edge arrived while channel busy

Behaviour:
- Reset:
  - pinout=0, busy=0, overrun=0, all channels IDLE, edge-detect register t0_d=0.
  - First cycle after reset release: pinout = pol (inactive level).
- Edge detect: t0_edge = t0 & ~t0_d, with t0_d registered each cycle. Edge cycle E = the clk edge at which t0_edge=1 is sampled.
- Arming at E, channel i IDLE & enable[i] & count[i]!=0:
  - Latch delay/width/period/count into shadow registers; later input changes do not affect the running sequence.
  - Enter DELAY; busy[i]=1 from E+1.
- Arming at E, channel i IDLE with enable[i]=0 or count[i]==0: no action, busy stays 0.
- Per-channel FSM: IDLE -> DELAY -> HIGH -> (LOW -> HIGH)* -> IDLE.
  - DELAY lasts D clocks (D=0 allowed). First active pinout cycle is E+D+1.
  - HIGH lasts W clocks; pinout active = ~pol.
  - Effective period Pe = max(period, W+1): a gap of at least 1 inactive cycle between burst pulses.
  - LOW lasts Pe-W clocks; then next HIGH.
  - After the N-th HIGH: IDLE, with no trailing LOW. busy falls in the same cycle pinout returns inactive.
- W=0: no active cycles. Channel still steps through DELAY and N periods of Pe=max(period,1), busy high accordingly. Used as a silent timer.
- Counters:
  - Internal WIDTH+1 bits so delay+width and period arithmetic never wraps.
  - Maximum delay or period = 2^WIDTH-1 clocks, exact.
- Retrigger: a t0_edge while channel busy is ignored for that channel (no restart, no shadow update). overrun[i] set at next clk.
- overrun:
  - clr_overrun clears all bits.
  - Simultaneous clr_overrun and new overrun event: set wins.
- abort:
  - At the next clk, all channels IDLE, busy=0, pinout=pol.
  - abort coincident with t0_edge: abort wins, no channel arms.
  - overrun unaffected.
- Channels are fully independent; identical programming produces cycle-identical outputs on all channels.
- Changing pol mid-pulse takes effect on the next clk (pinout = active ^ pol, registered).
- Async reset mid-burst: immediate return to reset values; no pulse resumes after release.

Test Plan:
- Single pulse: ch0 delay=5 width=3 count=1 pol=0, t0 edge at E -> pinout[0]=1 on E+6..E+8; busy[0]=1 on E+1..E+8; low elsewhere.
- Zero delay and burst: ch1 delay=0 width=2 period=5 count=3 -> pinout[1] high E+1..2, E+6..7, E+11..12; busy[1] falls at E+13.
- Period clamp and silent timer:
  - ch2 width=4 period=2 count=2 delay=1 -> high E+2..5, low E+6, high E+7..10.
  - ch3 width=0 delay=10 count=1 -> pinout never active; busy E+1..E+10.
- Retrigger/overrun: second t0 edge at E+3 during ch0 sequence -> ch0 output unchanged from first scenario, overrun[0]=1 from E+4. clr_overrun pulse clears it. Same-cycle clr and new overrun -> overrun stays 1.
- Abort and polarity: pol[1]=1 burst running, abort at E+7 -> pinout[1]=1 (inactive) and busy=0 from E+8. t0 held high (no new edge) -> no rearm.
- Enable/count gating and reset: enable[2]=0 or count[2]=0 -> no busy, no pulse. reset_n low mid-burst -> pinout/busy/overrun 0 immediately; no output after release until next t0 edge.

Source files
------------

// File: rtl/delay_pulse_burst_if.sv
// delay_pulse_burst_if: trigger, programming and status bundle for delay_pulse_burst
// Ports (via modports):
//   t0, abort, clr_overrun      : trigger / control strobes
//   enable, pol                 : per-channel enable and output polarity
//   delay, width, period, count : per-channel programming, channel i at [i*W +: W]
//   pinout, busy, overrun       : per-channel outputs and status
interface delay_pulse_burst_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic                   t0;
    logic                   abort;
    logic                   clr_overrun;
    logic [NCH-1:0]         enable;
    logic [NCH-1:0]         pol;
    logic [NCH*WIDTH-1:0]   delay;
    logic [NCH*WIDTH-1:0]   width;
    logic [NCH*WIDTH-1:0]   period;
    logic [NCH*CNT_W-1:0]   count;
    logic [NCH-1:0]         pinout;
    logic [NCH-1:0]         busy;
    logic [NCH-1:0]         overrun;

    modport master (
        output t0, abort, clr_overrun, enable, pol, delay, width, period, count,
        input  pinout, busy, overrun
    );

    modport slave (
        input  t0, abort, clr_overrun, enable, pol, delay, width, period, count,
        output pinout, busy, overrun
    );
endinterface

// File: rtl/delay_pulse_burst.sv
// delay_pulse_burst: multi-channel delay/pulse generator with per-channel bursts
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of delay_pulse_burst_if (trigger, programming, outputs)
module delay_pulse_burst #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    delay_pulse_burst_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    localparam logic [WIDTH:0]   ONE = 1;
    localparam logic [CNT_W-1:0] N1  = 1;

    logic t0_d;
    logic t0_edge;

    assign t0_edge = bus.t0 & ~t0_d;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) t0_d <= 1'b0;
        else          t0_d <= bus.t0;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           st, st_n;
        logic [WIDTH:0]   cnt, cnt_n;
        logic [CNT_W-1:0] n, n_n;
        logic [WIDTH:0]   w, pe;
        logic [WIDTH:0]   d_in, w_in, p_in, pe_in, w_e, pe_e;
        logic [CNT_W-1:0] c_in;
        logic             arm, go, po, bz, ov;

        assign d_in  = {1'b0, bus.delay[i*WIDTH +: WIDTH]};
        assign w_in  = {1'b0, bus.width[i*WIDTH +: WIDTH]};
        assign p_in  = {1'b0, bus.period[i*WIDTH +: WIDTH]};
        assign c_in  = bus.count[i*CNT_W +: CNT_W];
        // Guarantee at least one inactive cycle between burst pulses
        assign pe_in = (p_in > w_in) ? p_in : w_in + ONE;
        assign arm   = (st == IDLE) & t0_edge & bus.enable[i] & (c_in != '0) & ~bus.abort;
        // On the arming cycle the shadows are not loaded yet, so use the live inputs
        assign w_e   = arm ? w_in : w;
        assign pe_e  = arm ? pe_in : pe;

        // cnt holds the cycles left in the current state after this one; go marks the
        // start of a pulse, where zero-length DELAY/HIGH phases are skipped
        always_comb begin
            st_n  = st;
            cnt_n = cnt;
            n_n   = n;
            go    = 1'b0;
            case (st)
                IDLE: if (arm) begin
                    st_n  = DELAY;
                    cnt_n = d_in - ONE;
                    n_n   = c_in;
                    go    = (d_in == '0);
                end
                DELAY, LOW: if (cnt == '0) go = 1'b1; else cnt_n = cnt - ONE;
                HIGH: if (cnt != '0) cnt_n = cnt - ONE;
                      else if (n == N1) st_n = IDLE;
                      else begin
                          st_n  = LOW;
                          n_n   = n - N1;
                          cnt_n = pe - w - ONE;
                      end
                default: st_n = IDLE;
            endcase
            if (go) begin
                if (w_e != '0) begin
                    st_n  = HIGH;
                    cnt_n = w_e - ONE;
                end else if (n_n == N1) st_n = IDLE;
                else begin
                    st_n  = LOW;
                    n_n   = n_n - N1;
                    cnt_n = pe_e - ONE;
                end
            end
            if (bus.abort) st_n = IDLE;
        end

        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                st  <= IDLE;
                cnt <= '0;
                n   <= '0;
                w   <= '0;
                pe  <= '0;
                po  <= 1'b0;
                bz  <= 1'b0;
                ov  <= 1'b0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
                n   <= n_n;
                if (arm) begin
                    w  <= w_in;
                    pe <= pe_in;
                end
                po  <= (st_n == HIGH) ^ bus.pol[i];
                bz  <= st_n != IDLE;
                // Set has priority over clear
                ov  <= (ov & ~bus.clr_overrun) | (t0_edge & (st != IDLE));
            end

        assign bus.pinout[i]  = po;
        assign bus.busy[i]    = bz;
        assign bus.overrun[i] = ov;
    end
endmodule

// File: tb/tb_delay_pulse_burst.sv
// tb_delay_pulse_burst: directed self-checking bench for delay_pulse_burst
module tb_delay_pulse_burst;
    localparam int NCH = 4, WIDTH = 32, CNT_W = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    delay_pulse_burst_if #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    delay_pulse_burst #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic prog(input int ch, input int d, input int w, input int p, input int c);
        bus.delay[ch*WIDTH +: WIDTH]  = d;
        bus.width[ch*WIDTH +: WIDTH]  = w;
        bus.period[ch*WIDTH +: WIDTH] = p;
        bus.count[ch*CNT_W +: CNT_W]  = c[CNT_W-1:0];
    endtask

    // Leaves the bench #1 after edge E, i.e. looking at cycle E+1
    task automatic fire(input bit hold);
        @(negedge clk);
        bus.t0 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.t0 = 1'b0;
    endtask

    task automatic gap();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [NCH-1:0] ep;
        reset_n = 1'b0;
        bus.t0 = 1'b0; bus.abort = 1'b0; bus.clr_overrun = 1'b0;
        bus.enable = '0; bus.pol = 4'b1010;
        bus.delay = '0; bus.width = '0; bus.period = '0; bus.count = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.pinout !== 4'b0000) begin errors++; $display("FAIL reset pinout got %b exp 0000", bus.pinout); end
        checks++; if (bus.busy !== 4'b0000) begin errors++; $display("FAIL reset busy got %b exp 0000", bus.busy); end
        checks++; if (bus.overrun !== 4'b0000) begin errors++; $display("FAIL reset overrun got %b exp 0000", bus.overrun); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        ep = 4'b1010;
        checks++; if (bus.pinout !== ep) begin errors++; $display("FAIL reset first cycle pinout got %b exp %b", bus.pinout, ep); end
        bus.pol = '0;
        gap();
    endtask

    task automatic test_single();
        logic [NCH-1:0] ep, eb;
        prog(0, 5, 3, 0, 1);
        bus.enable = 4'b0001;
        fire(1'b0);
        for (int k = 1; k <= 12; k++) begin
            ep = '0; eb = '0;
            ep[0] = (k >= 6 && k <= 8);
            eb[0] = (k >= 1 && k <= 8);
            checks++; if (bus.pinout !== ep) begin errors++; $display("FAIL single pinout k=%0d got %b exp %b", k, bus.pinout, ep); end
            checks++; if (bus.busy !== eb) begin errors++; $display("FAIL single busy k=%0d got %b exp %b", k, bus.busy, eb); end
            @(posedge clk);
            #1;
        end
        checks++; if (bus.overrun !== 4'b0000) begin errors++; $display("FAIL single overrun got %b exp 0000", bus.overrun); end
        gap();
    endtask

    task automatic test_burst();
        logic [NCH-1:0] ep, eb;
        prog(1, 0, 2, 5, 3);
        bus.enable = 4'b0010;
        fire(1'b0);
        for (int k = 1; k <= 16; k++) begin
            ep = '0; eb = '0;
            ep[1] = (k == 1 || k == 2 || k == 6 || k == 7 || k == 11 || k == 12);
            eb[1] = (k <= 12);
            checks++; if (bus.pinout !== ep) begin errors++; $display("FAIL burst pinout k=%0d got %b exp %b", k, bus.pinout, ep); end
            checks++; if (bus.busy !== eb) begin errors++; $display("FAIL burst busy k=%0d got %b exp %b", k, bus.busy, eb); end
            @(posedge clk);
            #1;
        end
        gap();
    endtask

    task automatic test_clamp_silent();
        logic [NCH-1:0] ep, eb;
        prog(2, 1, 4, 2, 2);
        prog(3, 10, 0, 0, 1);
        bus.enable = 4'b1100;
        fire(1'b0);
        for (int k = 1; k <= 14; k++) begin
            ep = '0; eb = '0;
            ep[2] = (k >= 2 && k <= 5) || (k >= 7 && k <= 10);
            eb[2] = (k <= 10);
            eb[3] = (k <= 10);
            checks++; if (bus.pinout !== ep) begin errors++; $display("FAIL clamp_silent pinout k=%0d got %b exp %b", k, bus.pinout, ep); end
            checks++; if (bus.busy !== eb) begin errors++; $display("FAIL clamp_silent busy k=%0d got %b exp %b", k, bus.busy, eb); end
            @(posedge clk);
            #1;
        end
        gap();
    endtask

    task automatic test_retrigger();
        logic [NCH-1:0] ep, eb, eo;
        prog(0, 5, 3, 0, 1);
        bus.enable = 4'b0001;
        fire(1'b0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) bus.t0 = 1'b1;
            if (k == 4) bus.t0 = 1'b0;
            ep = '0; eb = '0; eo = '0;
            ep[0] = (k >= 6 && k <= 8);
            eb[0] = (k <= 8);
            eo[0] = (k >= 4);
            checks++; if (bus.pinout !== ep) begin errors++; $display("FAIL retrigger pinout k=%0d got %b exp %b", k, bus.pinout, ep); end
            checks++; if (bus.busy !== eb) begin errors++; $display("FAIL retrigger busy k=%0d got %b exp %b", k, bus.busy, eb); end
            checks++; if (bus.overrun !== eo) begin errors++; $display("FAIL retrigger overrun k=%0d got %b exp %b", k, bus.overrun, eo); end
            @(posedge clk);
            #1;
        end
        bus.clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_overrun = 1'b0;
        checks++; if (bus.overrun !== 4'b0000) begin errors++; $display("FAIL clr_overrun got %b exp 0000", bus.overrun); end
        gap();
        fire(1'b0);
        @(posedge clk); #1;
        bus.t0 = 1'b1;
        @(posedge clk); #1;
        bus.t0 = 1'b0;
        checks++; if (bus.overrun !== 4'b0001) begin errors++; $display("FAIL overrun set got %b exp 0001", bus.overrun); end
        @(posedge clk); #1;
        bus.t0 = 1'b1;
        bus.clr_overrun = 1'b1;
        @(posedge clk); #1;
        bus.t0 = 1'b0;
        bus.clr_overrun = 1'b0;
        checks++; if (bus.overrun !== 4'b0001) begin errors++; $display("FAIL overrun set_vs_clr got %b exp 0001", bus.overrun); end
        repeat (8) @(posedge clk);
        #1;
        bus.clr_overrun = 1'b1;
        @(posedge clk); #1;
        bus.clr_overrun = 1'b0;
        checks++; if (bus.overrun !== 4'b0000) begin errors++; $display("FAIL overrun final clr got %b exp 0000", bus.overrun); end
        gap();
    endtask

    task automatic test_abort_pol();
        logic [NCH-1:0] ep, eb;
        bus.pol = 4'b0010;
        prog(1, 0, 2, 5, 3);
        bus.enable = 4'b0010;
        @(posedge clk); #1;
        fire(1'b1);
        for (int k = 1; k <= 14; k++) begin
            if (k == 7) bus.abort = 1'b1;
            if (k == 8) bus.abort = 1'b0;
            ep = 4'b0010; eb = '0;
            if (k <= 7) begin
                ep[1] = !(k == 1 || k == 2 || k == 6 || k == 7);
                eb[1] = 1'b1;
            end
            checks++; if (bus.pinout !== ep) begin errors++; $display("FAIL abort_pol pinout k=%0d got %b exp %b", k, bus.pinout, ep); end
            checks++; if (bus.busy !== eb) begin errors++; $display("FAIL abort_pol busy k=%0d got %b exp %b", k, bus.busy, eb); end
            @(posedge clk);
            #1;
        end
        checks++; if (bus.overrun !== 4'b0000) begin errors++; $display("FAIL abort_pol overrun got %b exp 0000", bus.overrun); end
        bus.t0 = 1'b0;
        bus.pol = '0;
        gap();
    endtask

    task automatic test_gating();
        for (int pass = 0; pass < 2; pass++) begin
            prog(2, 1, 2, 4, (pass == 0) ? 5 : 0);
            bus.enable = (pass == 0) ? 4'b0000 : 4'b0100;
            fire(1'b0);
            for (int k = 1; k <= 8; k++) begin
                checks++; if (bus.busy !== 4'b0000) begin errors++; $display("FAIL gating%0d busy k=%0d got %b exp 0000", pass, k, bus.busy); end
                checks++; if (bus.pinout !== 4'b0000) begin errors++; $display("FAIL gating%0d pinout k=%0d got %b exp 0000", pass, k, bus.pinout); end
                @(posedge clk);
                #1;
            end
        end
        gap();
    endtask

    task automatic test_async_reset();
        prog(1, 0, 2, 5, 3);
        bus.enable = 4'b0010;
        fire(1'b0);
        @(posedge clk); #1;
        bus.t0 = 1'b1;
        @(posedge clk); #1;
        bus.t0 = 1'b0;
        checks++; if (bus.overrun !== 4'b0010) begin errors++; $display("FAIL async_reset pre overrun got %b exp 0010", bus.overrun); end
        checks++; if (bus.busy !== 4'b0010) begin errors++; $display("FAIL async_reset pre busy got %b exp 0010", bus.busy); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.pinout !== 4'b0000) begin errors++; $display("FAIL async_reset pinout got %b exp 0000", bus.pinout); end
        checks++; if (bus.busy !== 4'b0000) begin errors++; $display("FAIL async_reset busy got %b exp 0000", bus.busy); end
        checks++; if (bus.overrun !== 4'b0000) begin errors++; $display("FAIL async_reset overrun got %b exp 0000", bus.overrun); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.pinout !== 4'b0000) begin errors++; $display("FAIL async_reset post pinout k=%0d got %b exp 0000", k, bus.pinout); end
            checks++; if (bus.busy !== 4'b0000) begin errors++; $display("FAIL async_reset post busy k=%0d got %b exp 0000", k, bus.busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_clamp_silent();
        test_retrigger();
        test_abort_pol();
        test_gating();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
